// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MDU_BUSY = 1'b1
    } state_e;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_LOADUSE = 2'd1;
    localparam logic [1:0] CAUSE_MDU     = 2'd2;
    localparam logic [1:0] CAUSE_BRANCH  = 2'd3;

    localparam int MDU_LATENCY_DEFAULT = 32;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: ID/EX observations in, stage-register controls out.
interface pipe_hazard_ctrl_if;

    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic       ex_mem_read;
    logic [4:0] ex_rt;
    logic       id_jump;
    logic       ex_branch_taken;
    logic       mdu_start;

    logic       pc_write;
    logic       ifid_write;
    logic       ifid_flush;
    logic       idex_flush;
    logic       mdu_busy;
    logic [1:0] stall_cause;

    // Pipeline datapath side: supplies stage fields, consumes the controls.
    modport master (
        output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
               id_jump, ex_branch_taken, mdu_start,
        input  pc_write, ifid_write, ifid_flush, idex_flush, mdu_busy, stall_cause
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
               id_jump, ex_branch_taken, mdu_start,
        output pc_write, ifid_write, ifid_flush, idex_flush, mdu_busy, stall_cause
    );

endinterface

// File: rtl/hazard_perf_cnt.sv
// Free-running stall-cycle and flush-event counters; wrap at 2^32.
module hazard_perf_cnt (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o
);

    logic [31:0] stall_q;
    logic [31:0] flush_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (stall_i) stall_q <= stall_q + 32'd1;
            if (flush_i) flush_q <= flush_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_q;
    assign flush_cnt_o = flush_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Load-use / branch / jump / multi-cycle MDU hazard controller for the 5-stage pipe.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module pipe_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MDU_LATENCY = MDU_LATENCY_DEFAULT,
    parameter int CNT_W       = $clog2(MDU_LATENCY)
) (
    input  logic              clk,
    input  logic              reset,
    pipe_hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]       perf_stall_cycles,
    output logic [31:0]       perf_flush_events
`endif
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       load_use;
    logic       pc_write;
    logic       ifid_write;
    logic       ifid_flush;
    logic       idex_flush;
    logic [1:0] cause;

    // r0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign load_use = hz.ex_mem_read && (hz.ex_rt != 5'd0) &&
                      ((hz.ex_rt == hz.id_rs) || (hz.id_uses_rt && (hz.ex_rt == hz.id_rt)));

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value; reset is asynchronous, hence its place in the sensitivity list.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        cause      = CAUSE_NONE;

        if (reset) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            state_d    = RUN;
            cnt_d      = '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (hz.ex_branch_taken) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                        cause      = CAUSE_BRANCH;
                    end else if (hz.mdu_start) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        idex_flush = 1'b1;
                        cause      = CAUSE_MDU;
                        state_d    = MDU_BUSY;
                        cnt_d      = CNT_W'(MDU_LATENCY - 2);
                    end else if (load_use) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        idex_flush = 1'b1;
                        cause      = CAUSE_LOADUSE;
                    end else if (hz.id_jump) begin
                        ifid_flush = 1'b1;
                    end
                end
                MDU_BUSY: begin
                    // EX only holds bubbles here, so the inputs are deliberately ignored.
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_flush = 1'b1;
                    cause      = CAUSE_MDU;
                    if (cnt_q == '0) state_d = RUN;
                    else             cnt_d   = cnt_q - CNT_W'(1);
                end
                default: state_d = RUN;
            endcase
        end
    end

    assign hz.pc_write    = pc_write;
    assign hz.ifid_write  = ifid_write;
    assign hz.ifid_flush  = ifid_flush;
    assign hz.idex_flush  = idex_flush;
    assign hz.stall_cause = cause;
    assign hz.mdu_busy    = (state_q == MDU_BUSY) && !reset;

`ifdef HAZARD_PERF_EN
    hazard_perf_cnt u_perf (
        .clk         (clk),
        .reset       (reset),
        .stall_i     (!pc_write && !reset),
        .flush_i     (cause == CAUSE_BRANCH),
        .stall_cnt_o (perf_stall_cycles),
        .flush_cnt_o (perf_flush_events)
    );
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus a randomized run against a cycle model.
module tb_pipe_hazard_ctrl;
    import hazard_pkg::*;

    localparam int LAT = 4;

    // Output vector order: {pc_write, ifid_write, ifid_flush, idex_flush, mdu_busy, stall_cause[1:0]}
    localparam logic [6:0] V_RESET = 7'b0011_0_00;
    localparam logic [6:0] V_RUN   = 7'b1100_0_00;
    localparam logic [6:0] V_LU    = 7'b0001_0_01;
    localparam logic [6:0] V_BR    = 7'b1111_0_11;
    localparam logic [6:0] V_JMP   = 7'b1110_0_00;
    localparam logic [6:0] V_MDU0  = 7'b0001_0_10;
    localparam logic [6:0] V_BUSY  = 7'b0001_1_10;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    int   frz      = 0;   // model: front-end freeze cycles still owed after the current one

    pipe_hazard_ctrl_if hz ();

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_flush_events;
`endif

    pipe_hazard_ctrl #(.MDU_LATENCY(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
`ifdef HAZARD_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flush_events (perf_flush_events)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] obs();
        return {hz.pc_write, hz.ifid_write, hz.ifid_flush, hz.idex_flush, hz.mdu_busy, hz.stall_cause};
    endfunction

    // Reference: priority rules applied to the current inputs and the outstanding freeze.
    function automatic logic [6:0] model_out();
        logic lu;
        lu = hz.ex_mem_read && (hz.ex_rt != 0) &&
             ((hz.ex_rt == hz.id_rs) || (hz.id_uses_rt && (hz.ex_rt == hz.id_rt)));
        if (reset)                   return V_RESET;
        else if (frz > 0)            return V_BUSY;
        else if (hz.ex_branch_taken) return V_BR;
        else if (hz.mdu_start)       return V_MDU0;
        else if (lu)                 return V_LU;
        else if (hz.id_jump)         return V_JMP;
        else                         return V_RUN;
    endfunction

    task automatic model_tick();
        if (reset)                                    frz = 0;
        else if (frz > 0)                             frz = frz - 1;
        else if (!hz.ex_branch_taken && hz.mdu_start) frz = LAT - 1;
    endtask

    task automatic clear_inputs();
        hz.id_rs = 5'd0; hz.id_rt = 5'd0; hz.id_uses_rt = 1'b0;
        hz.ex_mem_read = 1'b0; hz.ex_rt = 5'd0; hz.id_jump = 1'b0;
        hz.ex_branch_taken = 1'b0; hz.mdu_start = 1'b0;
    endtask

    task automatic drive_random(input bit allow_reset);
        hz.id_rs           = 5'($urandom_range(0, 3));
        hz.id_rt           = 5'($urandom_range(0, 3));
        hz.id_uses_rt      = 1'($urandom_range(0, 1));
        hz.ex_mem_read     = 1'($urandom_range(0, 1));
        hz.ex_rt           = 5'($urandom_range(0, 3));
        hz.id_jump         = ($urandom_range(0, 4) == 0);
        hz.ex_branch_taken = ($urandom_range(0, 5) == 0);
        hz.mdu_start       = ($urandom_range(0, 7) == 0);
        reset              = allow_reset && ($urandom_range(0, 49) == 0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        #1;
        checks++;
        if (obs() !== V_RESET) begin failures++; $display("FAIL reset_initial: got %b want %b", obs(), V_RESET); end
        next_cycle();
        @(negedge clk);
        checks++;
        if (obs() !== V_RESET) begin failures++; $display("FAIL reset_held: got %b want %b", obs(), V_RESET); end
        reset = 1'b0;
        next_cycle();
        @(negedge clk);
        checks++;
        if (obs() !== V_RUN) begin failures++; $display("FAIL reset_release: got %b want %b", obs(), V_RUN); end
        next_cycle();
    endtask

    task automatic test_load_use();
        clear_inputs();
        hz.ex_mem_read = 1'b1; hz.ex_rt = 5'd5; hz.id_rt = 5'd5; hz.id_uses_rt = 1'b1; hz.id_rs = 5'd3;
        @(negedge clk);
        checks++;
        if (obs() !== V_LU) begin failures++; $display("FAIL load_use_rt: got %b want %b", obs(), V_LU); end
        next_cycle();
        hz.ex_mem_read = 1'b0;
        @(negedge clk);
        checks++;
        if (obs() !== V_RUN) begin failures++; $display("FAIL load_use_after_bubble: got %b want %b", obs(), V_RUN); end
        next_cycle();
        hz.ex_mem_read = 1'b1; hz.ex_rt = 5'd7; hz.id_rs = 5'd7; hz.id_rt = 5'd2; hz.id_uses_rt = 1'b0;
        @(negedge clk);
        checks++;
        if (obs() !== V_LU) begin failures++; $display("FAIL load_use_rs: got %b want %b", obs(), V_LU); end
        next_cycle();
        hz.ex_rt = 5'd0; hz.id_rs = 5'd0; hz.id_rt = 5'd0; hz.id_uses_rt = 1'b1;
        @(negedge clk);
        checks++;
        if (obs() !== V_RUN) begin failures++; $display("FAIL load_use_r0: got %b want %b", obs(), V_RUN); end
        next_cycle();
        hz.ex_rt = 5'd9; hz.id_rs = 5'd1; hz.id_rt = 5'd9; hz.id_uses_rt = 1'b0;
        @(negedge clk);
        checks++;
        if (obs() !== V_RUN) begin failures++; $display("FAIL load_use_rt_unused: got %b want %b", obs(), V_RUN); end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_branch_priority();
        clear_inputs();
        hz.ex_branch_taken = 1'b1; hz.id_jump = 1'b1; hz.mdu_start = 1'b1;
        hz.ex_mem_read = 1'b1; hz.ex_rt = 5'd4; hz.id_rs = 5'd4;
        @(negedge clk);
        checks++;
        if (obs() !== V_BR) begin failures++; $display("FAIL branch_priority: got %b want %b", obs(), V_BR); end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        checks++;
        if (obs() !== V_RUN) begin failures++; $display("FAIL branch_no_mdu_entry: got %b want %b", obs(), V_RUN); end
        next_cycle();
    endtask

    task automatic test_jump();
        clear_inputs();
        hz.id_jump = 1'b1;
        @(negedge clk);
        checks++;
        if (obs() !== V_JMP) begin failures++; $display("FAIL jump: got %b want %b", obs(), V_JMP); end
        next_cycle();
        hz.id_jump = 1'b0;
        @(negedge clk);
        checks++;
        if (obs() !== V_RUN) begin failures++; $display("FAIL jump_after: got %b want %b", obs(), V_RUN); end
        next_cycle();
    endtask

    task automatic test_mdu();
        clear_inputs();
        hz.mdu_start = 1'b1;
        @(negedge clk);
        checks++;
        if (obs() !== V_MDU0) begin failures++; $display("FAIL mdu_start: got %b want %b", obs(), V_MDU0); end
        next_cycle();
        for (int i = 2; i <= LAT; i++) begin
            drive_random(1'b0);
            @(negedge clk);
            checks++;
            if (obs() !== V_BUSY) begin failures++; $display("FAIL mdu_busy_cycle%0d: got %b want %b", i, obs(), V_BUSY); end
            next_cycle();
        end
        clear_inputs();
        @(negedge clk);
        checks++;
        if (obs() !== V_RUN) begin failures++; $display("FAIL mdu_return: got %b want %b", obs(), V_RUN); end
        next_cycle();
    endtask

    task automatic test_reset_mid_mdu();
        clear_inputs();
        hz.mdu_start = 1'b1;
        @(negedge clk);
        checks++;
        if (obs() !== V_MDU0) begin failures++; $display("FAIL rmid_start: got %b want %b", obs(), V_MDU0); end
        next_cycle();
        hz.mdu_start = 1'b0;
        @(negedge clk);
        checks++;
        if (obs() !== V_BUSY) begin failures++; $display("FAIL rmid_busy1: got %b want %b", obs(), V_BUSY); end
        next_cycle();
        #1 reset = 1'b1;
        #1;
        checks++;
        if (obs() !== V_RESET) begin failures++; $display("FAIL rmid_async: got %b want %b", obs(), V_RESET); end
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (obs() !== V_RUN) begin failures++; $display("FAIL rmid_release: got %b want %b", obs(), V_RUN); end
        next_cycle();
        @(negedge clk);
        checks++;
        if (obs() !== V_RUN) begin failures++; $display("FAIL rmid_no_residual: got %b want %b", obs(), V_RUN); end
        next_cycle();
    endtask

    task automatic test_random();
        reset = 1'b1;
        clear_inputs();
        frz = 0;
        next_cycle();
        for (int i = 0; i < 600; i++) begin
            drive_random(1'b1);
            @(negedge clk);
            checks++;
            if (obs() !== model_out()) begin
                failures++;
                $display("FAIL random_cycle%0d: got %b want %b", i, obs(), model_out());
            end
            model_tick();
            next_cycle();
        end
        reset = 1'b0;
        clear_inputs();
        next_cycle();
    endtask

`ifdef HAZARD_PERF_EN
    task automatic test_perf();
        reset = 1'b1;
        clear_inputs();
        next_cycle();
        checks++;
        if (perf_stall_cycles !== 32'd0 || perf_flush_events !== 32'd0) begin
            failures++;
            $display("FAIL perf_reset: got %0d/%0d want 0/0", perf_stall_cycles, perf_flush_events);
        end
        reset = 1'b0;
        hz.mdu_start = 1'b1;
        next_cycle();
        hz.mdu_start = 1'b0;
        repeat (LAT - 1) next_cycle();
        hz.ex_branch_taken = 1'b1;
        next_cycle();
        hz.ex_branch_taken = 1'b0;
        next_cycle();
        checks++;
        if (perf_stall_cycles !== 32'(LAT) || perf_flush_events !== 32'd1) begin
            failures++;
            $display("FAIL perf_counts: got %0d/%0d want %0d/1", perf_stall_cycles, perf_flush_events, LAT);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_load_use();
        test_branch_priority();
        test_jump();
        test_mdu();
        test_reset_mid_mdu();
        test_random();
`ifdef HAZARD_PERF_EN
        test_perf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Hazard and sequencing controller for the 5-stage pipeline. Drives PC write-enable, IF/ID write/flush and the ID/EX flush (CFlush) so that:
- load-use hazards get one bubble;
- jumps resolved in ID and branches resolved in EX squash wrong-path instructions;
- multi-cycle multiply/divide ops freeze the front end for a fixed latency.

It sits beside the ID stage, takes register indices from ID and control from EX, and feeds the IF/ID and ID/EX stage registers.

Parameters:
- MDU_LATENCY, 32, total EX-occupancy cycles of a multiply/divide op (legal range 2..64).
- CNT_W, $clog2(MDU_LATENCY), width of the wait counter.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- id_rs  in  5  rs field of instruction in ID
- id_rt  in  5  rt field of instruction in ID
- id_uses_rt  in  1  ID instruction reads rt as a source
- ex_mem_read  in  1  instruction in EX is a load
- ex_rt  in  5  destination rt of the load in EX
- id_jump  in  1  ID holds a taken j/jal/jr/jalr
- ex_branch_taken  in  1  EX branch resolved taken
- mdu_start  in  1  EX instruction is a multiply/divide issue (one-cycle pulse)
- pc_write  out  1  PC register enable
- ifid_write  out  1  IF/ID register enable
- ifid_flush  out  1  IF/ID clear to NOP
- idex_flush  out  1  ID/EX clear (connects to CFlush)
- mdu_busy  out  1  high while in MDU_BUSY
- stall_cause  out  2  0 none, 1 load-use, 2 mdu, 3 branch flush

Behaviour:
- Interface: reset is asynchronous, active-high; clock is clk. All state updates on posedge clk.
- State: two-state FSM {RUN, MDU_BUSY} plus CNT_W-bit down-counter cnt.
- Output logic: control outputs are combinational from state and inputs, consumed by the stage registers at the next edge.
- While reset is high:
  - state=RUN, cnt=0;
  - outputs forced to pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1, mdu_busy=0, stall_cause=0.
- Load-use condition: ex_mem_read && ex_rt!=0 && (ex_rt==id_rs || (id_uses_rt && ex_rt==id_rt)).
- RUN priority, highest first:
  - (a) ex_branch_taken: pc_write=1, ifid_write=1, ifid_flush=1, idex_flush=1, cause=3. Load-use, id_jump and mdu_start are ignored this cycle (wrong path, or mutually exclusive in EX).
  - (b) mdu_start: pc_write=0, ifid_write=0, idex_flush=1, cause=2. Next state MDU_BUSY, cnt<=MDU_LATENCY-2.
  - (c) load-use: pc_write=0, ifid_write=0, ifid_flush=0, idex_flush=1, cause=1. Exactly one bubble, because the next cycle EX holds a bubble with ex_mem_read=0.
  - (d) id_jump: pc_write=1, ifid_write=1, ifid_flush=1, idex_flush=0, cause=0.
  - (e) none of the above: pc_write=1, ifid_write=1, flushes 0, cause=0.
- MDU_BUSY:
  - pc_write=0, ifid_write=0, ifid_flush=0, idex_flush=1, mdu_busy=1, cause=2.
  - cnt decrements each cycle; when cnt==0, next state RUN.
  - Total front-end freeze = MDU_LATENCY cycles including the mdu_start cycle.
  - All inputs are ignored in MDU_BUSY (EX holds bubbles).
- Reset mid-MDU_BUSY: immediate return to RUN, cnt=0, no residual stall after deassertion.
- MDU_LATENCY=2: cnt loads 0, so exactly one MDU_BUSY cycle.
- Register index 0 never causes a load-use stall.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- When defined:
  - Adds outputs perf_stall_cycles[31:0] and perf_flush_events[31:0].
  - perf_stall_cycles increments each cycle pc_write=0 outside reset.
  - perf_flush_events increments each cycle cause==3.
  - Both counters wrap at 2^32-1 to 0 and reset to 0.
- When not defined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package hazard_pkg holds:
  - state enum {RUN, MDU_BUSY};
  - stall_cause constants CAUSE_NONE/LOADUSE/MDU/BRANCH;
  - default MDU_LATENCY.
- One sub-module, hazard_perf_cnt: two saturating-free 32-bit counters, instantiated only under HAZARD_PERF_EN.
- FSM and detection logic stay in the top module.

Test Plan:
- Load-use on rt: ex_mem_read=1, ex_rt=5, id_rt=5, id_uses_rt=1 → one cycle with pc_write=0, ifid_write=0, idex_flush=1, cause=1; next cycle (ex_mem_read=0) normal flow. Repeat with ex_rt=0 → no stall.
- Branch wins over load-use: ex_branch_taken=1 while load-use condition and id_jump are also true → ifid_flush=1, idex_flush=1, pc_write=1, cause=3.
- Jump in ID: id_jump=1 alone → ifid_flush=1, idex_flush=0, pc_write=1 for exactly one cycle.
- MDU sequencing, MDU_LATENCY=4: mdu_start pulse → pc_write=0 for 4 consecutive cycles, mdu_busy=1 for cycles 2-4, back to RUN on cycle 5. Inputs toggled during busy have no effect.
- Reset mid-MDU: assert reset asynchronously on the 2nd busy cycle → outputs go to reset values immediately; after deassertion, pc_write=1 on the first clock with no hazards.
- HAZARD_PERF_EN build: run the MDU test (4 stalls) plus one branch → perf_stall_cycles=4, perf_flush_events=1.
